// File: rtl/g15_drum_pkg.sv
// Shared drum geometry, position types and line-select decode for the
// recirculating drum line bank.
package g15_drum_pkg;

    localparam int WORD_BITS  = 29;
    localparam int WORDS      = 108;
    localparam int TRACK_BITS = WORD_BITS * WORDS;

    typedef logic [4:0] bitpos_t;
    typedef logic [6:0] wordpos_t;

    // Line numbers that cannot be expressed on the 5-bit select never match.
    function automatic logic sel_hits(input logic [4:0] sel, input int line_num);
        return (line_num >= 0) && (line_num < 32) && (sel == line_num[4:0]);
    endfunction

endpackage

// File: rtl/drum_track_en.sv
// One drum track: an N-bit recirculation shift register advanced on each
// enabled bit time; dout is the bit currently under the read head.
module drum_track_en #(
    parameter int N = g15_drum_pkg::TRACK_BITS
) (
    input  logic clk,
    input  logic en,
    input  logic din,
    output logic dout
);

    logic [N-1:0] sr_q;

    // NOTE: track storage has no reset; the bank's clear sweep zeroes it,
    // so each stage stays a plain enabled flop.
    always_ff @(posedge clk) begin
        if (en) begin
            sr_q <= {sr_q[N-2:0], din};
        end
    end

    assign dout = sr_q[N-1];

endmodule

// File: rtl/drum_line_bank.sv
// Bank of N_LINES recirculating drum tracks with binary source/destination
// selects, a shared drum-position counter and a one-revolution clear sweep.
module drum_line_bank #(
    parameter int N_LINES    = 12,
    parameter int FIRST_LINE = 7,
    parameter int WORD_BITS  = g15_drum_pkg::WORD_BITS,
    parameter int WORDS      = g15_drum_pkg::WORDS
) (
    input  logic               CLOCK,
    input  logic               rst_n,
    input  logic               bit_en,
    input  logic [4:0]         src_sel,
    input  logic               src_en,
    input  logic [4:0]         dst_sel,
    input  logic               tr,
    input  logic               wr_data,
    input  logic [N_LINES-1:0] wr_protect,
    output logic               eb,
    output logic [N_LINES-1:0] line_tap,
    output logic [4:0]         bit_pos,
    output logic [6:0]         word_pos,
    output logic               t0,
    output logic               busy
);

    import g15_drum_pkg::*;

    localparam int         TRACK_LEN = WORDS * WORD_BITS;
    localparam logic [0:0] ST_CLEAR  = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;
    localparam bitpos_t    LAST_BIT  = bitpos_t'(WORD_BITS - 1);
    localparam wordpos_t   LAST_WORD = wordpos_t'(WORDS - 1);

    logic [0:0]         state_q, state_d;
    bitpos_t            bit_pos_q, bit_pos_d;
    wordpos_t           word_pos_q, word_pos_d;
    logic               eb_q, eb_d;
    logic               running;
    logic               pos_wrap;
    logic               src_bit;
    logic [N_LINES-1:0] track_din;

    assign running  = (state_q == ST_RUN);
    assign pos_wrap = (bit_pos_q == LAST_BIT) && (word_pos_q == LAST_WORD);

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        bit_pos_d  = bit_pos_q;
        word_pos_d = word_pos_q;
        state_d    = state_q;
        if (bit_en) begin
            if (bit_pos_q == LAST_BIT) begin
                bit_pos_d  = '0;
                word_pos_d = (word_pos_q == LAST_WORD) ? '0 : word_pos_q + 1'b1;
            end else begin
                bit_pos_d = bit_pos_q + 1'b1;
            end
            // The sweep has fed zero into every position once the counter wraps.
            if (!running && pos_wrap) begin
                state_d = ST_RUN;
            end
        end
    end

    always_comb begin
        src_bit = 1'b0;
        for (int k = 0; k < N_LINES; k++) begin
            if (sel_hits(src_sel, FIRST_LINE + k)) begin
                src_bit = line_tap[k];
            end
        end
    end

    // eb samples the tap before this bit time's write lands, so a same-line
    // read during a write returns the old bit.
    always_comb begin
        eb_d = eb_q;
        if (bit_en) begin
            eb_d = running && src_en && src_bit;
        end
    end

    for (genvar k = 0; k < N_LINES; k++) begin : g_line
        logic wr_hit;

        assign wr_hit       = tr && sel_hits(dst_sel, FIRST_LINE + k) && !wr_protect[k];
        assign track_din[k] = !running ? 1'b0 : (wr_hit ? wr_data : line_tap[k]);

        drum_track_en #(
            .N (TRACK_LEN)
        ) u_track (
            .clk  (CLOCK),
            .en   (bit_en),
            .din  (track_din[k]),
            .dout (line_tap[k])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            bit_pos_q  <= '0;
            word_pos_q <= '0;
            eb_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_pos_q  <= bit_pos_d;
            word_pos_q <= word_pos_d;
            eb_q       <= eb_d;
        end
    end

    assign eb       = eb_q;
    assign bit_pos  = bit_pos_q;
    assign word_pos = word_pos_q;
    assign t0       = (bit_pos_q == '0) && (word_pos_q == '0);
    assign busy     = !running;

endmodule

// File: doc/drum_line_bank.md
# drum_line_bank

Parametrised bank of recirculating drum memory lines, the generalised successor to the fixed twelve-line long-line group. It holds `N_LINES` tracks of `WORDS` × `WORD_BITS` bits, with binary-coded source and destination line selects instead of one-hot decodes. It keeps its own drum-position counter and clears every track in one revolution after reset. It sits between the command decode / transfer logic and the early bus of the arithmetic section.

## Interface
Parameters:
- `N_LINES`, 12: number of lines in the bank.
- `FIRST_LINE`, 7: line number of local line 0; select values outside `FIRST_LINE..FIRST_LINE+N_LINES-1` address nothing.
- `WORD_BITS`, 29: bits per word.
- `WORDS`, 108: words per track; track length is `WORDS*WORD_BITS`, 3132 by default.

Ports:
- `CLOCK` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `bit_en` in 1: drum bit-time strobe; all shifting and counting happens only when it is high.
- `src_sel` in 5: source line number, binary.
- `src_en` in 1: source read enable.
- `dst_sel` in 5: destination line number, binary.
- `tr` in 1: transfer active; write gate.
- `wr_data` in 1: serial write bit.
- `wr_protect` in `N_LINES`: per-line write inhibit.
- `eb` out 1: registered early-bus bit of the selected source line.
- `line_tap` out `N_LINES`: raw track outputs, one per line.
- `bit_pos` out 5: current bit-in-word, 0..`WORD_BITS-1`.
- `word_pos` out 7: current word, 0..`WORDS-1`.
- `t0` out 1: high for the bit time where `bit_pos==0` and `word_pos==0`.
- `busy` out 1: clear sweep in progress.

## Operation
- The state machine has two states, CLEAR and RUN. Reset forces CLEAR.
- In CLEAR:
  - Every track is fed 0 on each `bit_en`.
  - `tr` and `src_en` are ignored.
  - `eb` is held at 0 and `busy` is 1.
- Leaving CLEAR:
  - The machine moves to RUN on the `bit_en` at which the position counter wraps from (`WORDS-1`, `WORD_BITS-1`) to (0,0).
  - Exactly `WORDS*WORD_BITS` enabled cycles are spent in CLEAR.
- Position counter:
  - `bit_pos` increments on `bit_en` and wraps at `WORD_BITS-1`.
  - `word_pos` increments on each `bit_pos` wrap and wraps at `WORDS-1`.
  - The counter runs in both states.
- Write path, for local line k in RUN:
  - The track input is `wr_data` when all of these hold: `tr`, `dst_sel==FIRST_LINE+k`, and `!wr_protect[k]`.
  - Otherwise the track input is the track output (recirculate).
- Read path, in RUN: `eb` is registered on `bit_en` as `src_en ? line_tap[src_sel-FIRST_LINE] : 0`. An out-of-range `src_sel` gives 0.
- Simultaneous read and write of the same line at the same position: `eb` returns the old bit and the new bit is stored.
- An out-of-range `dst_sel` writes nothing; every line recirculates.
- Reset mid-operation:
  - Counters go to 0 and the state goes to CLEAR.
  - Track contents are discarded by the clear sweep.
  - No partial write survives.

## Timing
- Reset values:
  - `eb`=0, `bit_pos`=0, `word_pos`=0, `busy`=1.
  - `t0`=1, because it is decoded combinationally from the position counter.
  - `line_tap` is undefined until the first full sweep completes, and is 0 thereafter.
- Track latency: a bit written at position p reappears on `line_tap` at position p on the next revolution, exactly `WORDS*WORD_BITS` enabled cycles later.
- `eb` lags `line_tap` by one enabled cycle.
- With `bit_en` low, all state holds and the outputs are stable.

## Structure
- Shared package `g15_drum_pkg`:
  - constants `WORD_BITS`, `WORDS`, `TRACK_BITS`;
  - typedefs `bitpos_t` (5 bits) and `wordpos_t` (7 bits).
- One sub-module, `drum_track_en`: a shift register with parameter `N`, clock enable `en`, ports `clk/en/din/dout`, and no reset. It is instantiated `N_LINES` times with a generate loop.
- The position counter and the CLEAR/RUN state live in the top of the block.

## Test plan
- Reset, then count enabled cycles: `busy` must stay 1 for exactly 3132 enabled cycles, then fall with `t0`=1 and `bit_pos`=`word_pos`=0. All `line_tap` bits must read 0 over the next revolution.
- Write and read back:
  - In RUN, drive `tr`=1, `dst_sel`=9 and `wr_data`=1 only at word 5, bit 3, with `src_sel`=9 and `src_en`=1.
  - `eb` must be 1 only at word 5, bit 4 of the next revolution.
  - Lines 7, 8 and 10..18 must remain all-zero.
- Protect: set `wr_protect[2]`=1 and write all-ones to line 9 for a full revolution. Line 9 must stay 0; the same write to line 10 must yield all ones.
- Bounds: `dst_sel`=19 and `dst_sel`=3 with `tr`=1 must change no line; `src_sel`=20 must give `eb`=0.
- Stall: hold `bit_en`=0 for 500 cycles mid-word. Counters and `eb` must stay frozen, and data position on resume must be unchanged.
- Reset mid-write:
  - Assert `rst_n`=0 during a transfer to line 12.
  - `busy` must return to 1 and counters to 0.
  - After the sweep, line 12 must read all zeros.
